// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered valid/ready result; optional iterative
// shift-add multiplier is compiled in when ALU_MUL_EN is defined.
module alu_mc #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    // Handshake: a request transfers on in_valid && in_ready at a rising edge,
    // a result transfers on out_valid && out_ready; result/zero/err hold while
    // out_valid && !out_ready, and the requester holds its inputs until accepted.

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_err;
    logic               accept;
    logic               is_mul;
    logic               load_single;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_res;
    logic               wr_err;

    assign shamt  = b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  alu_res = ~(a | b);
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0]         OP_MUL   = 4'b1010;
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               mul_start;
    logic               mul_done;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [SHAMT_W-1:0] cnt;

    assign is_mul  = (op == OP_MUL);
    assign acc_nxt = b_reg[0] ? (acc + a_reg) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (cnt == CNT_LAST)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
        mul_start = in_valid && in_ready && is_mul;
        mul_done  = (state == MUL) && (cnt == CNT_LAST);
    end

    // One shift-add step per cycle; b_reg is consumed LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (mul_start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == MUL) begin
            acc   <= acc_nxt;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + SHAMT_W'(1);
        end
    end
`else
    assign is_mul   = 1'b0;
    assign in_ready = rst_n && (!out_valid || out_ready);
`endif

    assign load_single = accept && !is_mul;

    always_comb begin
        wr_en  = load_single;
        wr_res = alu_res;
        wr_err = alu_err;
`ifdef ALU_MUL_EN
        if (mul_done) begin
            wr_en  = 1'b1;
            wr_res = acc_nxt;
            wr_err = 1'b0;
        end
`endif
    end

    // A write wins over a drain in the same cycle, so out_valid stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (wr_en) begin
            out_valid <= 1'b1;
            result    <= wr_res;
            zero      <= (wr_res == '0);
            err       <= wr_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=64); MUL cases run when
// ALU_MUL_EN is defined, otherwise op 1010 is checked as undefined.
module tb_alu_mc;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns 1 ns after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                          input logic ee);
        out_ready = 1'b1;
        issue(o, x, y);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, result, er);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_err"}, err, ee);
        @(negedge clk);
        check({tag, "_drain"}, out_valid, 0);
    endtask

    logic [3:0]   s_op [4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0110};
    logic [W-1:0] s_a  [4] = '{64'd1, 64'h00F0, 64'd1, 64'd5};
    logic [W-1:0] s_b  [4] = '{64'd2, 64'h0FF0, 64'h43, 64'd7};
    logic [W-1:0] s_e  [4] = '{64'd3, 64'h0F00, 64'd8, 64'hFFFF_FFFF_FFFF_FFFE};

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        single("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
        single("sra", 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
        single("srl", 4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0);
        single("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0);
        single("sltu", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
        single("undef_f", 4'b1111, 64'd7, 64'd9, 64'd0, 1'b1, 1'b1);
        single("undef_b", 4'b1011, 64'd7, 64'd9, 64'd0, 1'b1, 1'b1);
        single("and", 4'b0000, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
               64'h000F_000F_000F_000F, 1'b0, 1'b0);
        single("or", 4'b0001, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
               64'h0FFF_0FFF_0FFF_0FFF, 1'b0, 1'b0);
        single("nor", 4'b1100, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
               64'hF000_F000_F000_F000, 1'b0, 1'b0);

        // Back-to-back stream: one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                check("stream_valid", out_valid, 1);
                check("stream_res", result, exp_q.pop_front());
            end
            if (i < 4) begin
                check("stream_ready", in_ready, 1);
                in_valid = 1'b1;
                op = s_op[i];
                a = s_a[i];
                b = s_b[i];
                exp_q.push_back(s_e[i]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_end", out_valid, 0);

        // Stall with a pending request, then drain and accept on the same edge.
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 4'b0010;
        a = 64'd10;
        b = 64'd20;
        exp_q.push_back(64'd30);
        @(negedge clk);
        op = 4'b0011;
        a = 64'h00F0;
        b = 64'h000F;
        exp_q.push_back(64'h00FF);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_res", result, exp_q[0]);
            check("stall_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_ready", in_ready, 1);
        check("unstall_res", result, exp_q.pop_front());
        @(negedge clk);
        in_valid = 1'b0;
        check("replace_valid", out_valid, 1);
        check("replace_res", result, exp_q[0]);
        @(negedge clk);
        check("drained_valid", out_valid, 0);
        check("drained_hold", result, exp_q.pop_front());

`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        issue(4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid || in_ready) seen++;
        end
        check("mul_busy", seen, 0);
        @(negedge clk);
        check("mul_valid", out_valid, 1);
        check("mul_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
        check("mul_err", err, 0);
        check("mul_zero", zero, 0);
        @(negedge clk);
        check("mul_drain", out_valid, 0);

        issue(4'b1010, 64'd5, 64'd7);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mulrst_valid", out_valid, 0);
        check("mulrst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mulrst_ready_back", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mulrst_no_result", seen, 0);
        single("add_after_rst", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0);
`else
        single("mul_undef", 4'b1010, 64'd2, 64'd3, 64'd0, 1'b1, 1'b1);
`endif

        // Reset while a result is held clears the output register.
        out_ready = 1'b0;
        issue(4'b0010, 64'd1, 64'd1);
        @(negedge clk);
        check("hold_res", result, 64'd2);
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready_back", in_ready, 1);
        single("add_final", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
